// File: rtl/vga_sprite_engine.sv
// VGA raster generator with a single rectangular sprite that bounces or wraps.
// All pins are registered from the pixel counters; the sprite moves at most once per frame.
module vga_sprite_engine #(
    parameter int                 H_ACTIVE = 640,
    parameter int                 H_FP     = 16,
    parameter int                 H_SYNC   = 96,
    parameter int                 H_BP     = 48,
    parameter int                 V_ACTIVE = 480,
    parameter int                 V_FP     = 10,
    parameter int                 V_SYNC   = 2,
    parameter int                 V_BP     = 33,
    parameter logic               HS_POL   = 1'b0,
    parameter logic               VS_POL   = 1'b0,
    parameter int                 CLK_DIV  = 2,
    parameter int                 COLOR_W  = 12,
    parameter int                 SPR_W    = 32,
    parameter int                 SPR_H    = 32,
    parameter int                 STEP     = 4,
    parameter logic [COLOR_W-1:0] FG_COLOR = 12'hF00,
    parameter logic [COLOR_W-1:0] BG_COLOR = 12'h00F
) (
    input  logic               clk50M,
    input  logic               reset,
    input  logic [1:0]         key,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC,
    output logic [COLOR_W-1:0] VGA_D,
    output logic               de,
    output logic               frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_T   = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
    // Wide enough for counters and for pos+STEP before the edge clamp.
    localparam int CW      = $clog2(MAX_T + STEP + 1);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] XMAX_C     = CW'(H_ACTIVE - SPR_W);
    localparam logic [CW-1:0] YMAX_C     = CW'(V_ACTIVE - SPR_H);
    localparam logic [CW-1:0] SPR_W_C    = CW'(SPR_W);
    localparam logic [CW-1:0] SPR_H_C    = CW'(SPR_H);
    localparam logic [CW-1:0] STEP_C     = CW'(STEP);

    // One-axis motion step; returns {new_dir, new_pos}, dir 0 = increasing.
    function automatic logic [CW:0] axis_next(input logic [CW-1:0] pos, input logic dir,
                                              input logic [CW-1:0] pmax, input logic wrap);
        logic [CW-1:0] pos_n;
        logic          dir_n;
        pos_n = pos;
        dir_n = dir;
        if (wrap) begin
            if (!dir) begin
                if (pos + STEP_C > pmax) pos_n = '0;
                else                     pos_n = pos + STEP_C;
            end else begin
                if (pos < STEP_C) pos_n = pmax;
                else              pos_n = pos - STEP_C;
            end
        end else begin
            if (!dir) begin
                if (pos + STEP_C >= pmax) begin
                    pos_n = pmax;
                    dir_n = 1'b1;
                end else begin
                    pos_n = pos + STEP_C;
                end
            end else begin
                if (pos <= STEP_C) begin
                    pos_n = '0;
                    dir_n = 1'b0;
                end else begin
                    pos_n = pos - STEP_C;
                end
            end
        end
        return {dir_n, pos_n};
    endfunction

    logic [DW-1:0]      div_q, div_d;
    logic [CW-1:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [1:0]         key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic               key1_prev_q, key1_prev_d;
    logic               mode_q, mode_d;
    logic [CW-1:0]      x_q, x_d, y_q, y_d;
    logic               dx_q, dx_d, dy_q, dy_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic [COLOR_W-1:0] data_q, data_d;
    logic               de_q, de_d, tick_q, tick_d;
    logic               pix_en_s, h_wrap_s, tick_s, hs_s, vs_s, vis_s, in_spr_s;

    // Next-state logic: counters, key sync, sprite motion and pixel decode.
    always_comb begin
        pix_en_s = (div_q == DIV_LAST);
        h_wrap_s = pix_en_s && (h_cnt_q == H_LAST);
        tick_s   = h_wrap_s && (v_cnt_q == V_ACT_LAST);

        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

        if (pix_en_s) begin
            h_cnt_d = h_wrap_s ? '0 : h_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q;
        end

        if (h_wrap_s) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
            v_cnt_d = v_cnt_q;
        end

        key_meta_d  = key;
        key_sync_d  = key_meta_q;
        key1_prev_d = key_sync_q[1];
        // The toggled mode is used directly so a toggle on the tick cycle applies immediately.
        mode_d      = mode_q ^ (key_sync_q[1] & ~key1_prev_q);

        if (tick_s && key_sync_q[0]) begin
            {dx_d, x_d} = axis_next(x_q, dx_q, XMAX_C, mode_d);
            {dy_d, y_d} = axis_next(y_q, dy_q, YMAX_C, mode_d);
        end else begin
            {dx_d, x_d} = {dx_q, x_q};
            {dy_d, y_d} = {dy_q, y_q};
        end

        hs_s     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_s     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        vis_s    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        in_spr_s = (h_cnt_q >= x_q) && (h_cnt_q < x_q + SPR_W_C) &&
                   (v_cnt_q >= y_q) && (v_cnt_q < y_q + SPR_H_C);

        hsync_d = hs_s ? HS_POL : ~HS_POL;
        vsync_d = vs_s ? VS_POL : ~VS_POL;
        de_d    = vis_s;
        tick_d  = tick_s;
        if (vis_s) begin
            data_d = in_spr_s ? FG_COLOR : BG_COLOR;
        end else begin
            data_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            div_q       <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            key_meta_q  <= 2'b00;
            key_sync_q  <= 2'b00;
            key1_prev_q <= 1'b0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            dx_q        <= 1'b0;
            dy_q        <= 1'b0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            data_q      <= '0;
            de_q        <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            key_meta_q  <= key_meta_d;
            key_sync_q  <= key_sync_d;
            key1_prev_q <= key1_prev_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            data_q      <= data_d;
            de_q        <= de_d;
            tick_q      <= tick_d;
        end
    end

    assign VGA_HSYNC  = hsync_q;
    assign VGA_VSYNC  = vsync_q;
    assign VGA_D      = data_q;
    assign de         = de_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine: default-timing raster checks plus reduced-timing
// instances for bounce, wrap, pause and mid-frame reset.
module tb_vga_sprite_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_a, rst_bc, rst_d;
    logic [1:0]  key_a, key_b, key_c, key_d;
    logic        hs_a, vs_a, de_a, tick_a, hs_b, vs_b, de_b, tick_b;
    logic        hs_c, vs_c, de_c, tick_c, hs_d, vs_d, de_d, tick_d;
    logic [11:0] d_a, d_b, d_c, d_d;

    vga_sprite_engine dut_a (
        .clk50M(clk), .reset(rst_a), .key(key_a), .VGA_HSYNC(hs_a), .VGA_VSYNC(vs_a),
        .VGA_D(d_a), .de(de_a), .frame_tick(tick_a));

    vga_sprite_engine #(.H_ACTIVE(64), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(48), .V_FP(2),
        .V_SYNC(2), .V_BP(2), .CLK_DIV(1), .SPR_W(8), .SPR_H(8), .STEP(4)) dut_b (
        .clk50M(clk), .reset(rst_bc), .key(key_b), .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b),
        .VGA_D(d_b), .de(de_b), .frame_tick(tick_b));

    vga_sprite_engine #(.H_ACTIVE(64), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(48), .V_FP(2),
        .V_SYNC(2), .V_BP(2), .CLK_DIV(1), .SPR_W(8), .SPR_H(8), .STEP(4)) dut_c (
        .clk50M(clk), .reset(rst_bc), .key(key_c), .VGA_HSYNC(hs_c), .VGA_VSYNC(vs_c),
        .VGA_D(d_c), .de(de_c), .frame_tick(tick_c));

    vga_sprite_engine #(.H_ACTIVE(64), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(48), .V_FP(2),
        .V_SYNC(2), .V_BP(2), .CLK_DIV(1), .SPR_W(8), .SPR_H(8), .STEP(4)) dut_d (
        .clk50M(clk), .reset(rst_d), .key(key_d), .VGA_HSYNC(hs_d), .VGA_VSYNC(vs_d),
        .VGA_D(d_d), .de(de_d), .frame_tick(tick_d));

    typedef struct {
        int frame;
        int x;
        int y;
        int dx;
        int dy;
    } move_vec_t;

    move_vec_t bounce_tbl[6];
    move_vec_t wrap_tbl[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for frame_tick", name);
    endtask

    task automatic wait_tick(input int which, output bit ok);
        bit hit;
        ok = 1'b0;
        for (int n = 0; n < 5000 && !ok; n++) begin
            @(negedge clk);
            case (which)
                1:       hit = tick_b;
                2:       hit = tick_c;
                default: hit = tick_d;
            endcase
            if (hit) ok = 1'b1;
        end
    endtask

    task automatic read_state(input int which, output int x, output int y, output int dx,
                              output int dy, output int mode);
        case (which)
            1: begin x = int'(dut_b.x_q); y = int'(dut_b.y_q); dx = int'(dut_b.dx_q);
                     dy = int'(dut_b.dy_q); mode = int'(dut_b.mode_q); end
            2: begin x = int'(dut_c.x_q); y = int'(dut_c.y_q); dx = int'(dut_c.dx_q);
                     dy = int'(dut_c.dy_q); mode = int'(dut_c.mode_q); end
            default: begin x = int'(dut_d.x_q); y = int'(dut_d.y_q); dx = int'(dut_d.dx_q);
                     dy = int'(dut_d.dy_q); mode = int'(dut_d.mode_q); end
        endcase
    endtask

    task automatic run_table(input int which, input string tag, input move_vec_t tbl[6]);
        int frames = 0;
        int x, y, dx, dy, mode;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            while (frames < tbl[i].frame) begin
                wait_tick(which, ok);
                if (!ok) begin
                    timeout_fail(tag);
                    return;
                end
                frames++;
            end
            read_state(which, x, y, dx, dy, mode);
            check($sformatf("%s f%0d x", tag, tbl[i].frame), x, tbl[i].x);
            check($sformatf("%s f%0d y", tag, tbl[i].frame), y, tbl[i].y);
            check($sformatf("%s f%0d dx", tag, tbl[i].frame), dx, tbl[i].dx);
            check($sformatf("%s f%0d dy", tag, tbl[i].frame), dy, tbl[i].dy);
        end
    endtask

    // Pause, resume with a mode toggle, then reset in the middle of a frame.
    task automatic pause_and_reset();
        int x, y, dx, dy, mode;
        bit ok;
        bit found;
        for (int i = 0; i < 5; i++) begin
            wait_tick(3, ok);
            if (!ok) begin timeout_fail("pause run-up"); return; end
        end
        read_state(3, x, y, dx, dy, mode);
        check("pause x before", x, 20);
        key_d[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_tick(3, ok);
            check($sformatf("pause tick %0d seen", i), int'(ok), 1);
            read_state(3, x, y, dx, dy, mode);
            check($sformatf("pause tick %0d x", i), x, 20);
        end
        key_d[0] = 1'b1;
        key_d[1] = 1'b1;
        wait_tick(3, ok);
        if (!ok) begin timeout_fail("resume"); return; end
        key_d[1] = 1'b0;
        read_state(3, x, y, dx, dy, mode);
        check("resume x", x, 24);
        check("resume mode", mode, 1);
        for (int i = 0; i < 4; i++) begin
            wait_tick(3, ok);
            if (!ok) begin timeout_fail("reset run-up"); return; end
        end
        read_state(3, x, y, dx, dy, mode);
        check("pre-reset x", x, 40);
        found = 1'b0;
        for (int n = 0; n < 6000 && !found; n++) begin
            @(negedge clk);
            if (dut_d.h_cnt_q == 7'd30 && dut_d.v_cnt_q == 7'd20) found = 1'b1;
        end
        check("mid-frame point reached", int'(found), 1);
        rst_d = 1'b1;
        @(posedge clk);
        #1;
        read_state(3, x, y, dx, dy, mode);
        check("midrst x", x, 0);
        check("midrst y", y, 0);
        check("midrst mode", mode, 0);
        check("midrst h_cnt", int'(dut_d.h_cnt_q), 0);
        check("midrst v_cnt", int'(dut_d.v_cnt_q), 0);
        check("midrst hsync", int'(hs_d), 1);
        check("midrst vsync", int'(vs_d), 1);
        check("midrst de", int'(de_d), 0);
        check("midrst data", int'(d_d), 0);
        @(negedge clk);
        rst_d = 1'b0;
    endtask

    // Vertical geometry on the reduced instance: 70x54 totals, one cycle per pixel.
    task automatic vert_geometry();
        int fall1 = 0, fall2 = 0, rise1 = 0, de_cnt = 0;
        logic prev = 1'b1;
        for (int k = 1; k <= 12000 && fall2 == 0; k++) begin
            @(negedge clk);
            if (prev && !vs_b) begin
                if (fall1 == 0) fall1 = k;
                else            fall2 = k;
            end
            if (!prev && vs_b && fall1 != 0 && rise1 == 0) rise1 = k;
            if (fall1 != 0 && fall2 == 0 && de_b) de_cnt++;
            prev = vs_b;
        end
        check("vsync low cycles", rise1 - fall1, 140);
        check("frame length", fall2 - fall1, 3780);
        check("de cycles per frame", de_cnt, 3072);
    endtask

    initial begin
        int hfall1 = 0, hfall2 = 0, hrise1 = 0, de_line = 0;
        logic prev_hs = 1'b1;

        bounce_tbl[0] = '{1, 4, 4, 0, 0};
        bounce_tbl[1] = '{10, 40, 40, 0, 1};
        bounce_tbl[2] = '{11, 44, 36, 0, 1};
        bounce_tbl[3] = '{13, 52, 28, 0, 1};
        bounce_tbl[4] = '{14, 56, 24, 1, 1};
        bounce_tbl[5] = '{15, 52, 20, 1, 1};
        wrap_tbl[0]   = '{1, 4, 4, 0, 0};
        wrap_tbl[1]   = '{10, 40, 40, 0, 0};
        wrap_tbl[2]   = '{11, 44, 0, 0, 0};
        wrap_tbl[3]   = '{13, 52, 8, 0, 0};
        wrap_tbl[4]   = '{14, 56, 12, 0, 0};
        wrap_tbl[5]   = '{15, 0, 16, 0, 0};

        rst_a = 1'b1; rst_bc = 1'b1; rst_d = 1'b1;
        key_a = 2'b01; key_b = 2'b01; key_c = 2'b01; key_d = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset hsync", int'(hs_a), 1);
        check("reset vsync", int'(vs_a), 1);
        check("reset data", int'(d_a), 0);
        check("reset de", int'(de_a), 0);
        check("reset tick", int'(tick_a), 0);
        rst_a = 1'b0;

        // k counts clock edges since reset release; output at edge k shows pixel (k-1)/2.
        for (int k = 1; k <= 3400; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first de", int'(de_a), 1);
                check("pixel 0 colour", int'(d_a), 12'hF00);
            end
            if (k == 64)  check("pixel 31 colour", int'(d_a), 12'hF00);
            if (k == 65)  check("pixel 32 colour", int'(d_a), 12'h00F);
            if (prev_hs && !hs_a) begin
                if (hfall1 == 0) hfall1 = k;
                else if (hfall2 == 0) hfall2 = k;
            end
            if (!prev_hs && hs_a && hrise1 == 0) hrise1 = k;
            if (k <= 1600 && de_a) de_line++;
            prev_hs = hs_a;
        end
        check("hsync fall offset", hfall1 - 1, 1312);
        check("hsync low cycles", hrise1 - hfall1, 192);
        check("hsync period", hfall2 - hfall1, 1600);
        check("de cycles per line", de_line, 1280);

        rst_bc = 1'b0;
        rst_d  = 1'b0;
        fork
            run_table(1, "bounce", bounce_tbl);
            begin
                repeat (5) @(negedge clk);
                key_c[1] = 1'b1;
                repeat (5) @(negedge clk);
                key_c[1] = 1'b0;
                run_table(2, "wrap", wrap_tbl);
            end
            pause_and_reset();
            vert_geometry();
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
